sevenseg_scan_driver: RTL and testbench

Time-multiplexed, parametrised seven-segment display driver for the Nexys A7 eight-digit display and smaller variants. It latches a packed vector of hex nibbles plus per-digit decimal-point and enable masks, then scans one digit per refresh slot. Each slot opens with a ghosting guard interval in which all anodes are off. It replaces free-running `sel`-driven decode with a self-timed scanner and tear-free update. It sits between the lab top level (switches, counters, UART payloads) and the board `seg`/`dp`/`an` pins.

---
 rtl/sevenseg_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// Self-timed multiplexed seven-segment scanner with guard blanking,
// leading-zero suppression and slot-aligned (tear-free) data updates.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic                    lz_en_i,
  input  logic                    load_i,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    slot_start_o
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic                    lz;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   dp;
    logic [4*NUM_DIGITS-1:0] dig;
  } disp_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pend_q, pend_d;
  disp_t                 pnd_q, pnd_d;
  disp_t                 act_q, act_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  slot_q;

  logic                  wrap;
  logic                  in_guard;
  logic [3:0]            nib;
  logic                  dp_b;
  logic                  en_b;
  logic [IW-1:0]         hi;
  logic                  dark;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending data only moves to the active set on a slot boundary;
  // a load on the boundary cycle itself waits for the next one.
  always_comb begin
    pnd_d  = pnd_q;
    pend_d = pend_q;
    act_d  = act_q;
    if (wrap && pend_q) begin
      act_d  = pnd_q;
      pend_d = 1'b0;
    end
    if (load_i) begin
      pnd_d.lz  = lz_en_i;
      pnd_d.en  = en_i;
      pnd_d.dp  = dp_i;
      pnd_d.dig = digits_i;
      pend_d    = 1'b1;
    end
  end

  if (BLANK_CYCLES == 0) begin : g_noguard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (cnt_q < CW'(BLANK_CYCLES));
  end

  always_comb begin
    nib  = '0;
    dp_b = 1'b0;
    en_b = 1'b0;
    hi   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        nib  = act_q.dig[4*i +: 4];
        dp_b = act_q.dp[i];
        en_b = act_q.en[i];
      end
      if (act_q.dig[4*i +: 4] != 4'h0) begin
        hi = IW'(i);
      end
    end
  end

  // Digit 0 can never sit above hi, so it is never suppressed.
  assign dark = !en_b || (act_q.lz && (idx_q > hi));

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7f;
    dp_d  = 1'b1;
    if (!in_guard && !dark) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex7(nib);
      dp_d  = ~dp_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pnd_q  <= '0;
      act_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7f;
      dp_q   <= 1'b1;
      slot_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pnd_q  <= pnd_d;
      act_q  <= act_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      slot_q <= (cnt_q == '0);
    end
  end

  assign seg          = seg_q;
  assign dp           = dp_q;
  assign an           = an_q;
  assign slot_start_o = slot_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench: 4-digit scanner (8-cycle slots, 2-cycle guard)
// plus a 1-digit, zero-guard instance.
module tb_sevenseg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic        lz_en_i;
  logic        load_i;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        slot_start_o;

  logic [3:0]  d1_digits;
  logic [0:0]  d1_dp_i;
  logic [0:0]  d1_en_i;
  logic        d1_lz;
  logic        d1_load;
  logic [6:0]  d1_seg;
  logic        d1_dp;
  logic [0:0]  d1_an;
  logic        d1_slot;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .rst(rst),
    .digits_i(digits_i), .dp_i(dp_i), .en_i(en_i),
    .lz_en_i(lz_en_i), .load_i(load_i),
    .seg(seg), .dp(dp), .an(an),
    .slot_start_o(slot_start_o)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .digits_i(d1_digits), .dp_i(d1_dp_i), .en_i(d1_en_i),
    .lz_en_i(d1_lz), .load_i(d1_load),
    .seg(d1_seg), .dp(d1_dp), .an(d1_an),
    .slot_start_o(d1_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           nm;
    logic [15:0]     dig;
    logic [3:0]      dpm;
    logic [3:0]      en;
    logic            lz;
    logic [3:0]      lit;
    logic [3:0][6:0] sg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs[9];
  int   t;
  int   n_chk;
  int   n_pass;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%h exp=%h",
                  nm, t, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  // After edge t the outputs reflect internal state t-1.
  task automatic tick_chk(input string nm, input int d,
                          input logic [6:0] es,
                          input logic edp);
    int         c;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edx;
    tick();
    c = (t - 1) % RD;
    if (c < BC || d < 0) begin
      ean = 4'hf; eseg = 7'h7f; edx = 1'b1;
    end else begin
      ean = ~(4'b0001 << d); eseg = es; edx = edp;
    end
    chk(nm, 32'({an, seg, dp, slot_start_o}),
        32'({ean, eseg, edx, (c == 0)}));
  endtask

  task automatic run_slot(input string nm, input int d,
                          input logic [6:0] es,
                          input logic edp,
                          input int la = -1,
                          input logic [15:0] da = 16'h0,
                          input int lb = -1,
                          input logic [15:0] db = 16'h0);
    for (int j = 0; j < RD; j++) begin
      if (j == la || j == lb) begin
        digits_i = (j == la) ? da : db;
        en_i = 4'hf; dp_i = 4'h0; lz_en_i = 1'b0;
        load_i = 1'b1;
      end
      tick_chk(nm, d, es, edp);
      load_i = 1'b0;
    end
  endtask

  task automatic apply_vec(input vec_t v);
    digits_i = v.dig; dp_i = v.dpm;
    en_i = v.en; lz_en_i = v.lz;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    repeat (31) tick();
    for (int i = 0; i < N; i++) begin
      run_slot(v.nm, v.lit[i] ? i : -1,
               v.sg[i], v.dpo[i]);
    end
  endtask

  initial begin
    vecs[0] = '{"scan", 16'h3A70, 4'b0100, 4'b1111, 1'b0,
      4'b1111, {7'h30, 7'h08, 7'h78, 7'h40}, 4'b1011};
    vecs[1] = '{"lz5", 16'h0005, 4'b0000, 4'b1111, 1'b1,
      4'b0001, {7'h7f, 7'h7f, 7'h7f, 7'h12}, 4'b1111};
    vecs[2] = '{"lz0", 16'h0000, 4'b0000, 4'b1111, 1'b1,
      4'b0001, {7'h7f, 7'h7f, 7'h7f, 7'h40}, 4'b1111};
    vecs[3] = '{"en", 16'h3A70, 4'b0100, 4'b1011, 1'b0,
      4'b1011, {7'h30, 7'h7f, 7'h78, 7'h40}, 4'b1111};
    vecs[4] = '{"lzmid", 16'h0B0C, 4'b1001, 4'b1111, 1'b1,
      4'b0111, {7'h7f, 7'h03, 7'h40, 7'h46}, 4'b1110};
    vecs[5] = '{"hex1", 16'h8E6D, 4'b1111, 4'b1111, 1'b1,
      4'b1111, {7'h00, 7'h06, 7'h02, 7'h21}, 4'b0000};
    vecs[6] = '{"hex2", 16'hF942, 4'b0000, 4'b1111, 1'b0,
      4'b1111, {7'h0e, 7'h10, 7'h19, 7'h24}, 4'b1111};
    vecs[7] = '{"nolz", 16'h0001, 4'b0000, 4'b1111, 1'b0,
      4'b1111, {7'h40, 7'h40, 7'h40, 7'h79}, 4'b1111};
    vecs[8] = vecs[0];

    digits_i = '0; dp_i = '0; en_i = '0;
    lz_en_i = 1'b0; load_i = 1'b0;
    d1_digits = '0; d1_dp_i = '0; d1_en_i = '0;
    d1_lz = 1'b0; d1_load = 1'b0;
    t = 0; n_chk = 0; n_pass = 0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_out", 32'({an, seg, dp, slot_start_o}),
          32'({4'hf, 7'h7f, 1'b1, 1'b0}));
    end
    rst = 1'b0;

    for (int s = 0; s < N; s++) run_slot("empty", -1, 7'h7f, 1'b1);

    foreach (vecs[k]) apply_vec(vecs[k]);

    run_slot("tf_d0", 0, 7'h40, 1'b1);
    run_slot("tf_d1", 1, 7'h78, 1'b1, 4, 16'h1111);
    run_slot("tf_d2", 2, 7'h79, 1'b1);
    run_slot("tf_d3", 3, 7'h79, 1'b1,
             1, 16'h2222, 4, 16'h5555);
    run_slot("tf_d0b", 0, 7'h12, 1'b1, 7, 16'h8888);
    run_slot("tf_d1b", 1, 7'h12, 1'b1);
    run_slot("tf_d2b", 2, 7'h00, 1'b1);

    tick();
    tick();
    digits_i = 16'h4444; en_i = 4'hf; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    chk("pre_rst", 32'({an, seg}), 32'({4'b0111, 7'h00}));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({an, seg, dp, slot_start_o}),
        32'({4'hf, 7'h7f, 1'b1, 1'b0}));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold", 32'({an, seg, dp, slot_start_o}),
        32'({4'hf, 7'h7f, 1'b1, 1'b0}));
    rst = 1'b0;
    t = 0;
    for (int s = 0; s < N; s++) run_slot("post_rst", -1, 7'h7f, 1'b1);
    apply_vec(vecs[0]);

    d1_digits = 4'h6; d1_en_i = 1'b1;
    d1_dp_i = 1'b1; d1_load = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      d1_load = 1'b0;
      if ((t % 32) <= 4)
        chk("one_dark", 32'({d1_an, d1_seg, d1_dp, d1_slot}),
            32'({1'b1, 7'h7f, 1'b1, ((t - 1) % 4 == 0)}));
      else
        chk("one_lit", 32'({d1_an, d1_seg, d1_dp, d1_slot}),
            32'({1'b0, 7'h02, 1'b0, ((t - 1) % 4 == 0)}));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
